fifo_uart_tx: RTL and testbench

Read-side consumer for the 8-bit first-word-fall-through FIFO. Whenever the FIFO reports non-empty, the block takes the head byte and pops it with a single-cycle read request. It then serializes the byte on a UART-style line (8N1, LSB first) at a fixed clocks-per-bit rate. It sits between the FIFO's data/status pins and the off-chip serial pin, and is the FIFO's drain path.

---
 rtl/fifo_uart_tx.sv | 145 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-bit first-word-fall-through FIFO onto a UART line (8N1, LSB first).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  input  logic        tx_enable,
  output logic        fifo_read_request,
  output logic        tx,
  output logic        busy,
  output logic [15:0] bytes_sent
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    LOAD,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          bit_done;

  assign bit_done = (bit_cnt == CNT_LAST);

  // tx is registered with the level of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      bit_cnt           <= '0;
      bit_idx           <= '0;
      shift_reg         <= '0;
      tx                <= 1'b1;
      busy              <= 1'b0;
      fifo_read_request <= 1'b0;
      bytes_sent        <= '0;
    end else begin
      fifo_read_request <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          bit_cnt <= '0;
          if (tx_enable && !fifo_empty) begin
            state <= SETTLE;
          end
        end

        SETTLE: begin
          if (fifo_empty || !tx_enable) begin
            state <= IDLE;
          end else begin
            state             <= LOAD;
            busy              <= 1'b1;
            fifo_read_request <= 1'b1;
          end
        end

        LOAD: begin
          // The pop lands on this edge, so the head is still the byte being sent.
          shift_reg <= fifo_data;
          bit_cnt   <= '0;
          tx        <= 1'b0;
          state     <= START;
        end

        START: begin
          if (bit_done) begin
            state   <= DATA;
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shift_reg[0];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= ^shift_reg;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state   <= STOP;
            bit_cnt <= '0;
            tx      <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_done) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            tx         <= 1'b1;
            bytes_sent <= bytes_sent + 16'd1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed + randomized bench with a queue-based FIFO and a frame-level line model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  fifo_data = '0;
  logic        fifo_empty = 1'b1;
  logic        tx_enable = 1'b0;
  logic        fifo_read_request;
  logic        tx;
  logic        busy;
  logic [15:0] bytes_sent;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_data         (fifo_data),
    .fifo_empty        (fifo_empty),
    .tx_enable         (tx_enable),
    .fifo_read_request (fifo_read_request),
    .tx                (tx),
    .busy              (busy),
    .bytes_sent        (bytes_sent)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int illegal_pulses = 0;
  int sent_model = 0;
  bit pop_pending = 1'b0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_bytes[$];
  bit tx_log[$];
  bit busy_log[$];
  bit req_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'($urandom) : fifo_q[0];
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_bytes.push_back(b);
    drive_fifo();
  endtask

  function automatic void clear_logs();
    tx_log.delete();
    busy_log.delete();
    req_log.delete();
  endfunction

  // One clock: sample outputs mid-cycle, then let the FIFO model react to last cycle's pop.
  task automatic step();
    @(negedge clk);
    if (fifo_read_request && fifo_empty) illegal_pulses++;
    tx_log.push_back(tx);
    busy_log.push_back(busy);
    req_log.push_back(fifo_read_request);
    if (pop_pending && fifo_q.size() > 0) fifo_q.delete(0);
    pop_pending = fifo_read_request;
    drive_fifo();
  endtask

  function automatic int pulses();
    int c = 0;
    foreach (req_log[i]) if (req_log[i]) c++;
    return c;
  endfunction

  function automatic int tx_high();
    int c = 0;
    foreach (tx_log[i]) if (tx_log[i]) c++;
    return c;
  endfunction

  function automatic bit frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic wait_tx_low(input string tag, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tx_log[$] !== 1'b0 && n < limit);
    if (tx_log[$] !== 1'b0) begin
      tests++;
      failed++;
      $error("FAIL %s timeout: observed tx=1 after %0d cycles, expected start bit", tag, n);
    end
  endtask

  // Walk the line log, matching each start bit to the next expected byte.
  task automatic analyze(input string tag, input bit gap_check, output int frames);
    int i;
    int last_end;
    i = 1;
    last_end = -1;
    frames = 0;
    while (i < tx_log.size()) begin
      if (tx_log[i] == 1'b0) begin
        logic [7:0] b;
        bit ok;
        ok = (exp_bytes.size() > 0);
        b  = ok ? exp_bytes.pop_front() : 8'h00;
        if (!(req_log[i-1] && busy_log[i-1])) ok = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
          if (i + k >= tx_log.size()) ok = 1'b0;
          else if (tx_log[i+k] !== frame_bit(b, k / CPB) || busy_log[i+k] !== 1'b1 ||
                   req_log[i+k] !== 1'b0) ok = 1'b0;
        end
        if (i + FRAME_CYC < busy_log.size() && busy_log[i+FRAME_CYC]) ok = 1'b0;
        check($sformatf("%s frame %02h", tag, b), 32'(ok), 32'd1);
        if (gap_check && last_end >= 0) check({tag, " gap"}, i - last_end, 3);
        last_end = i + FRAME_CYC;
        i = last_end;
        frames++;
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    int n;
    int frames;
    int cnt;
    int s;
    logic [7:0] b1;

    // Reset held with a non-empty FIFO.
    reset = 1'b1;
    tx_enable = 1'b1;
    push(8'h5A);
    repeat (3) begin
      step();
      check("reset", {tx, busy, fifo_read_request, bytes_sent}, {3'b100, 16'h0000});
    end
    fifo_q.delete();
    exp_bytes.delete();
    drive_fifo();
    step();
    reset = 1'b0;

    // Reset during DATA bit 3, then 100 cycles idle with an empty FIFO.
    clear_logs();
    push(8'($urandom));
    wait_tx_low("rst", 20, n);
    repeat (4 * CPB + 1) step();
    reset = 1'b1;
    step();
    check("rst mid", {tx, busy, fifo_read_request}, 3'b100);
    check("rst bytes", bytes_sent, 32'(sent_model));
    reset = 1'b0;
    exp_bytes.delete();
    clear_logs();
    repeat (100) step();
    check("empty pulses", pulses(), 0);
    check("empty tx", tx_high(), 100);
    check("empty bytes", bytes_sent, 32'(sent_model));
    check("rst popped", fifo_q.size(), 0);

    // Single byte 0xA5 with first-byte latency.
    clear_logs();
    push(8'hA5);
    wait_tx_low("A5", 20, n);
    check("latency", n, 3);
    repeat (FRAME_CYC + 5) step();
    analyze("A5", 1'b0, frames);
    sent_model += 1;
    check("A5 frames", frames, 1);
    check("A5 pulses", pulses(), 1);
    check("A5 bytes", bytes_sent, 32'(sent_model));

`ifdef FIFO_UART_TX_PARITY_EN
    clear_logs();
    push(8'h07);
    wait_tx_low("par", 20, n);
    s = tx_log.size() - 1;
    repeat (FRAME_CYC + 5) step();
    check("parity bit", 32'(tx_log[s + 9 * CPB + 1]), 32'd1);
    analyze("par", 1'b0, frames);
    sent_model += 1;
    check("par frames", frames, 1);
    check("par bytes", bytes_sent, 32'(sent_model));
`endif

    // Back-to-back 0x00, 0xFF.
    clear_logs();
    push(8'h00);
    push(8'hFF);
    repeat (2 * (FRAME_CYC + 3) + 10) step();
    analyze("b2b", 1'b1, frames);
    sent_model += 2;
    check("b2b frames", frames, 2);
    check("b2b pulses", pulses(), 2);
    check("b2b bytes", bytes_sent, 32'(sent_model));

    // tx_enable dropped during DATA of frame 1 with a second byte waiting.
    clear_logs();
    b1 = 8'($urandom);
    push(b1);
    push(8'($urandom));
    wait_tx_low("en", 20, n);
    repeat (2 * CPB + 2) step();
    tx_enable = 1'b0;
    repeat (FRAME_CYC + 20) step();
    analyze("en", 1'b0, frames);
    sent_model += 1;
    check("en frames", frames, 1);
    check("en pulses", pulses(), 1);
    check("en left", fifo_q.size(), 1);
    check("en bytes", bytes_sent, 32'(sent_model));
    clear_logs();
    tx_enable = 1'b1;
    repeat (FRAME_CYC + 10) step();
    analyze("en2", 1'b0, frames);
    sent_model += 1;
    check("en2 frames", frames, 1);
    check("en2 bytes", bytes_sent, 32'(sent_model));

    // Random burst of bytes.
    clear_logs();
    cnt = int'($urandom_range(3, 6));
    for (int k = 0; k < cnt; k++) push(8'($urandom));
    repeat (cnt * (FRAME_CYC + 3) + 10) step();
    analyze("rnd", 1'b1, frames);
    sent_model += cnt;
    check("rnd frames", frames, cnt);
    check("rnd pulses", pulses(), cnt);
    check("rnd bytes", bytes_sent, 32'(sent_model));

    check("illegal pulses", illegal_pulses, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
